gpu_writeback_arbiter: RTL and testbench



---
 rtl/gpu_writeback_arbiter.sv | 128 ++++++++++++
 tb/tb_gpu_writeback_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_writeback_arbiter.sv
// Writeback arbiter: ALU results (priority) and FIFO-buffered load returns share the register-file write port.
// Define WB_BYPASS_EN to let a load return skip the empty FIFO when the ALU is idle.
module gpu_writeback_arbiter #(
    parameter  int unsigned LDQ_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(LDQ_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [3:0]       alu_rd,
    input  logic [63:0]      alu_data,
    input  logic             ld_issue,
    input  logic [3:0]       ld_issue_rd,
    input  logic             mem_rsp_valid,
    output logic             mem_rsp_ready,
    input  logic [3:0]       mem_rsp_rd,
    input  logic [63:0]      mem_rsp_data,
    output logic             rf_we,
    output logic [3:0]       rf_rd_addr,
    output logic [63:0]      rf_rd_data,
    output logic [15:0]      busy_mask,
    output logic [CNT_W-1:0] ldq_count,
    output logic             waw_err
);

    localparam int unsigned PTR_W = $clog2(LDQ_DEPTH);
    localparam logic [3:0]  ZERO_REG = 4'hF;

    typedef struct packed {
        logic [3:0]  rd;
        logic [63:0] data;
    } wb_entry_t;

    wb_entry_t        mem_q [LDQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             we_q, we_d;
    logic [3:0]       addr_q, addr_d;
    logic [63:0]      data_q, data_d;
    logic [15:0]      busy_q, busy_d;
    logic             waw_q, waw_d;

    logic      empty, full, push, pop, byp;
    wb_entry_t head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(LDQ_DEPTH));
    assign head  = mem_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
    assign byp = !alu_valid && empty && mem_rsp_valid;
`else
    assign byp = 1'b0;
`endif

    assign mem_rsp_ready = !full;
    assign push          = mem_rsp_valid && !full && !byp;
    assign pop           = !alu_valid && !empty;

    // Output selection, scoreboard and WAW detection
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        waw_d   = waw_q | (alu_valid && (alu_rd != ZERO_REG) && busy_q[alu_rd]);
        count_d = count_q;
        if (alu_valid) begin
            we_d   = (alu_rd != ZERO_REG);
            addr_d = alu_rd;
            data_d = alu_data;
        end else if (pop) begin
            we_d           = (head.rd != ZERO_REG);
            addr_d         = head.rd;
            data_d         = head.data;
            busy_d[head.rd] = 1'b0;
        end else if (byp) begin
            we_d               = (mem_rsp_rd != ZERO_REG);
            addr_d             = mem_rsp_rd;
            data_d             = mem_rsp_data;
            busy_d[mem_rsp_rd] = 1'b0;
        end
        // A new issue to the same register overrides the clear above
        if (ld_issue && (ld_issue_rd != ZERO_REG)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= '0;
            waw_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            waw_q   <= waw_d;
        end
    end

    // FIFO storage; validity is tracked by the reset pointers
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{rd: mem_rsp_rd, data: mem_rsp_data};
    end

    assign rf_we      = we_q;
    assign rf_rd_addr = addr_q;
    assign rf_rd_data = data_q;
    assign busy_mask  = busy_q;
    assign ldq_count  = count_q;
    assign waw_err    = waw_q;

endmodule

// File: tb/tb_gpu_writeback_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_gpu_writeback_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [3:0]    alu_rd;
    logic [63:0]   alu_data;
    logic          ld_issue;
    logic [3:0]    ld_issue_rd;
    logic          mem_rsp_valid;
    logic          mem_rsp_ready;
    logic [3:0]    mem_rsp_rd;
    logic [63:0]   mem_rsp_data;
    logic          rf_we;
    logic [3:0]    rf_rd_addr;
    logic [63:0]   rf_rd_data;
    logic [15:0]   busy_mask;
    logic [CW-1:0] ldq_count;
    logic          waw_err;

    always #5 clk = ~clk;

    gpu_writeback_arbiter #(.LDQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rd(mem_rsp_rd), .mem_rsp_data(mem_rsp_data),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .busy_mask(busy_mask), .ldq_count(ldq_count), .waw_err(waw_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output register, pending-load set, queue of returns
    typedef struct {
        logic [3:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy [16];
    logic        m_we;
    logic [3:0]  m_addr;
    logic [63:0] m_data;
    logic        m_waw;

    always @(posedge clk or negedge rst_n) begin
        bit   rdy, taken_direct;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_we = 1'b0; m_addr = 4'h0; m_data = 64'h0; m_waw = 1'b0;
        end else begin
            rdy = (mq.size() < DEPTH);
            taken_direct = 1'b0;
            if (alu_valid && alu_rd != 4'hF && m_busy[alu_rd]) m_waw = 1'b1;
            if (alu_valid) begin
                m_we = (alu_rd != 4'hF); m_addr = alu_rd; m_data = alu_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = (e.rd != 4'hF); m_addr = e.rd; m_data = e.data;
                m_busy[e.rd] = 1'b0;
            end else if (BYP && mem_rsp_valid) begin
                m_we = (mem_rsp_rd != 4'hF); m_addr = mem_rsp_rd; m_data = mem_rsp_data;
                m_busy[mem_rsp_rd] = 1'b0;
                taken_direct = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (mem_rsp_valid && rdy && !taken_direct) begin
                e.rd = mem_rsp_rd; e.data = mem_rsp_data;
                mq.push_back(e);
            end
            if (ld_issue && ld_issue_rd != 4'hF) m_busy[ld_issue_rd] = 1'b1;
        end
    end

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Model comparison, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_we", 64'(rf_we), 64'(m_we));
            if (m_we) begin
                chk("m_addr", 64'(rf_rd_addr), 64'(m_addr));
                chk("m_data", rf_rd_data, m_data);
            end
            chk("m_busy", 64'(busy_mask), 64'(m_busy_vec()));
            chk("m_count", 64'(ldq_count), 64'(mq.size()));
            chk("m_ready", 64'(mem_rsp_ready), 64'(mq.size() < DEPTH));
            chk("m_waw", 64'(waw_err), 64'(m_waw));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 4'h0; alu_data = 64'h0;
        ld_issue = 1'b0; ld_issue_rd = 4'h0;
        mem_rsp_valid = 1'b0; mem_rsp_rd = 4'h0; mem_rsp_data = 64'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        cyc();
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_ready", 64'(mem_rsp_ready), 64'd1);
        chk("rst_count", 64'(ldq_count), 64'd0);

        // ALU write, then r15 suppression
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 64'h0004_0003_0002_0001;
        cyc();
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_addr", 64'(rf_rd_addr), 64'd3);
        chk("alu_data", rf_rd_data, 64'h0004_0003_0002_0001);
        alu_rd = 4'hF;
        cyc();
        chk("alu_r15_we", 64'(rf_we), 64'd0);
        idle();

        // Load to r5 with scoreboard
        ld_issue = 1'b1; ld_issue_rd = 4'd5;
        cyc();
        ld_issue = 1'b0;
        chk("ld_busy_set", 64'(busy_mask[5]), 64'd1);
        mem_rsp_valid = 1'b1; mem_rsp_rd = 4'd5; mem_rsp_data = 64'hAAAA;
        cyc();
        mem_rsp_valid = 1'b0;
        if (BYP) begin
            chk("ld_byp_we", 64'(rf_we), 64'd1);
            chk("ld_byp_addr", 64'(rf_rd_addr), 64'd5);
            chk("ld_byp_busy", 64'(busy_mask[5]), 64'd0);
        end else begin
            chk("ld_n1_we", 64'(rf_we), 64'd0);
            chk("ld_n1_count", 64'(ldq_count), 64'd1);
            chk("ld_n1_busy", 64'(busy_mask[5]), 64'd1);
        end
        cyc();
        if (!BYP) begin
            chk("ld_n2_we", 64'(rf_we), 64'd1);
            chk("ld_n2_addr", 64'(rf_rd_addr), 64'd5);
            chk("ld_n2_data", rf_rd_data, 64'hAAAA);
        end
        chk("ld_busy_clr", 64'(busy_mask[5]), 64'd0);
        idle();
        cyc();

        // ALU stream fills the FIFO; 5th return refused
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1'b1; alu_rd = 4'(i); alu_data = {$urandom(), $urandom()};
            mem_rsp_valid = (i < 5); mem_rsp_rd = 4'(8 + i); mem_rsp_data = 64'(256 + i);
            cyc();
        end
        chk("fill_count", 64'(ldq_count), 64'd4);
        chk("fill_ready", 64'(mem_rsp_ready), 64'd0);
        idle();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("drain_we", 64'(rf_we), 64'd1);
            chk("drain_addr", 64'(rf_rd_addr), 64'(8 + k));
            chk("drain_data", rf_rd_data, 64'(256 + k));
        end
        cyc();

        // ALU beats FIFO head; WAW on pending r5
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 64'h11;
        mem_rsp_valid = 1'b1; mem_rsp_rd = 4'd7; mem_rsp_data = 64'h77;
        ld_issue = 1'b1; ld_issue_rd = 4'd5;
        cyc();
        mem_rsp_valid = 1'b0; ld_issue = 1'b0;
        alu_rd = 4'd2; alu_data = 64'h22;
        cyc();
        chk("prio_alu_addr", 64'(rf_rd_addr), 64'd2);
        chk("prio_fifo_held", 64'(ldq_count), 64'd1);
        alu_valid = 1'b0;
        cyc();
        chk("prio_ld_addr", 64'(rf_rd_addr), 64'd7);
        chk("prio_ld_data", rf_rd_data, 64'h77);
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 64'h55;
        cyc();
        chk("waw_set", 64'(waw_err), 64'd1);
        chk("waw_alu_we", 64'(rf_we), 64'd1);
        idle();
        repeat (3) cyc();
        chk("waw_sticky", 64'(waw_err), 64'd1);

        // Reset with queued entries and busy bits
        alu_valid = 1'b1; alu_rd = 4'd0; ld_issue = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_issue_rd = 4'(9 + i);
            mem_rsp_valid = 1'b1; mem_rsp_rd = 4'(9 + i); mem_rsp_data = 64'(i);
            cyc();
        end
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_we", 64'(rf_we), 64'd0);
        chk("mrst_addr", 64'(rf_rd_addr), 64'd0);
        chk("mrst_data", rf_rd_data, 64'd0);
        chk("mrst_busy", 64'(busy_mask), 64'd0);
        chk("mrst_count", 64'(ldq_count), 64'd0);
        chk("mrst_ready", 64'(mem_rsp_ready), 64'd1);
        chk("mrst_waw", 64'(waw_err), 64'd0);
        cyc();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mrst_nostale", 64'(rf_we), 64'd0);
        end

        // Randomized traffic with phases of heavy ALU load
        for (int n = 0; n < 3000; n++) begin
            alu_valid     = ($urandom_range(0, 99) < (((n / 200) % 2 == 0) ? 40 : 90));
            alu_rd        = 4'($urandom_range(0, 15));
            alu_data      = {$urandom(), $urandom()};
            ld_issue      = ($urandom_range(0, 2) == 0);
            ld_issue_rd   = 4'($urandom_range(0, 15));
            mem_rsp_valid = ($urandom_range(0, 1) == 1);
            mem_rsp_rd    = 4'($urandom_range(0, 15));
            mem_rsp_data  = {$urandom(), $urandom()};
            cyc();
        end
        idle();
        repeat (10) cyc();
        chk("final_drained", 64'(ldq_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
